// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Shares the single AXI read port between the instruction cache and the data
//   cache. One request is accepted at a time with round-robin priority. It is
//   issued as a single AR transaction, and the R beats are steered back to the
//   request's owner. Data reads that fall in the line of a pending write-back
//   are held off until the write retires.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   inst_rd_* / data_rd_*      request handshake (req, type, addr in; rdy out)
//   inst_ret_* / data_ret_*    return beats (valid, last, data)
//   wr_pending, wr_line_addr   write-back buffer state used for the hazard check
//   ar*                        AXI read address channel
//   r*                         AXI read data channel
//   bus_err                    one-cycle pulse on a bad rresp or a beat-count mismatch
module axi_rd_arbiter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_rd_req,
  input  logic [2:0]  inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  output logic [31:0] inst_ret_data,
  input  logic        data_rd_req,
  input  logic [2:0]  data_rd_type,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_rdy,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] data_ret_data,
  input  logic        wr_pending,
  input  logic [27:0] wr_line_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e      state_q, state_d;
  logic        owner_q;      // 1: data cache owns the transaction
  logic        fav_data_q;   // 1: data wins a tie
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [8:0]  beat_cnt_q;
  logic [8:0]  beat_exp_q;

  logic        data_ok;
  logic        grant_inst;
  logic        grant_data;
  logic [2:0]  sel_type;
  logic [31:0] sel_addr;

  // A data read into the line still waiting in the write-back buffer would
  // return stale memory contents.
  assign data_ok    = data_rd_req & ~(wr_pending & (data_rd_addr[31:4] == wr_line_addr));
  assign grant_data = data_ok & (~inst_rd_req | fav_data_q);
  assign grant_inst = inst_rd_req & ~grant_data;
  assign sel_type   = grant_data ? data_rd_type : inst_rd_type;
  assign sel_addr   = grant_data ? data_rd_addr : inst_rd_addr;

  assign arid    = {3'b000, owner_q};
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state_q == StAr) & ~reset;

  // rid is deliberately ignored: only one transaction is ever outstanding.
  always_comb begin
    state_d        = state_q;
    inst_rd_rdy    = 1'b0;
    data_rd_rdy    = 1'b0;
    rready         = 1'b0;
    inst_ret_valid = 1'b0;
    inst_ret_last  = 1'b0;
    inst_ret_data  = 32'h0;
    data_ret_valid = 1'b0;
    data_ret_last  = 1'b0;
    data_ret_data  = 32'h0;
    bus_err        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!reset) begin
          inst_rd_rdy = grant_inst;
          data_rd_rdy = grant_data;
          if (grant_inst || grant_data) state_d = StAr;
        end
      end
      StAr: begin
        if (arready) state_d = StR;
      end
      StR: begin
        // Gated by reset so a beat arriving during reset is never consumed.
        if (!reset) begin
          rready = 1'b1;
          if (rvalid) begin
            if (owner_q) begin
              data_ret_valid = 1'b1;
              data_ret_last  = rlast;
              data_ret_data  = rdata;
            end else begin
              inst_ret_valid = 1'b1;
              inst_ret_last  = rlast;
              inst_ret_data  = rdata;
            end
            if ((rresp != 2'b00) || (rlast && ((beat_cnt_q + 9'd1) != beat_exp_q))) begin
              bus_err = 1'b1;
            end
            if (rlast) state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      fav_data_q <= 1'b1;
      addr_q     <= 32'h0;
      len_q      <= 8'h0;
      size_q     <= 3'b000;
      beat_cnt_q <= 9'h0;
      beat_exp_q <= 9'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && (grant_inst || grant_data)) begin
        owner_q <= grant_data;
        addr_q  <= sel_addr;
        len_q   <= sel_type[2] ? 8'(LINE_WORDS - 1) : 8'd0;
        size_q  <= sel_type[2] ? 3'b010 : {1'b0, sel_type[1:0]};
      end
      if ((state_q == StAr) && arready) begin
        beat_cnt_q <= 9'h0;
        beat_exp_q <= 9'(len_q) + 9'd1;
      end
      if ((state_q == StR) && rvalid) begin
        beat_cnt_q <= beat_cnt_q + 9'd1;
        if (rlast) fav_data_q <= ~owner_q;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: word/line reads, round-robin alternation,
// write-back hazard hold-off, bus error pulses and reset mid-transaction.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_req, data_rd_req;
  logic [2:0]  inst_rd_type, data_rd_type;
  logic [31:0] inst_rd_addr, data_rd_addr;
  logic        inst_rd_rdy, data_rd_rdy;
  logic        inst_ret_valid, inst_ret_last, data_ret_valid, data_ret_last;
  logic [31:0] inst_ret_data, data_ret_data;
  logic        wr_pending;
  logic [27:0] wr_line_addr;
  logic [3:0]  arid, arcache, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp;
  logic        arvalid, arready, rlast, rvalid, rready, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid),
    .inst_ret_last(inst_ret_last), .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
    .data_ret_last(data_ret_last), .data_ret_data(data_ret_data),
    .wr_pending(wr_pending), .wr_line_addr(wr_line_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Checks the grant in the current IDLE cycle, then moves to the AR cycle.
  task automatic accept(input bit is_data);
    #1;
    check("inst_rd_rdy", 32'(inst_rd_rdy), 32'(!is_data));
    check("data_rd_rdy", 32'(data_rd_rdy), 32'(is_data));
    step();
  endtask

  task automatic ar_phase(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                          input logic [31:0] addr);
    #1;
    check("arvalid", 32'(arvalid), 32'd1);
    check("arid", 32'(arid), 32'(id));
    check("arlen", 32'(arlen), 32'(len));
    check("arsize", 32'(arsize), 32'(size));
    check("araddr", araddr, addr);
    check("arburst", 32'(arburst), 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  // Drives n beats with rlast on beat n; resp_beat gets rresp=2 (0: none).
  task automatic beats(input bit is_data, input int n, input logic [31:0] base,
                       input int resp_beat, input bit len_err);
    for (int i = 1; i <= n; i++) begin
      rvalid = 1'b1;
      rlast  = (i == n);
      rresp  = (i == resp_beat) ? 2'd2 : 2'd0;
      rdata  = base + 32'(i - 1);
      #1;
      check("rready", 32'(rready), 32'd1);
      check("rd_rdy_busy", 32'({inst_rd_rdy, data_rd_rdy}), 32'd0);
      if (is_data) begin
        check("data_ret_valid", 32'(data_ret_valid), 32'd1);
        check("data_ret_last", 32'(data_ret_last), 32'(i == n));
        check("data_ret_data", data_ret_data, base + 32'(i - 1));
        check("inst_ret_valid", 32'(inst_ret_valid), 32'd0);
      end else begin
        check("inst_ret_valid", 32'(inst_ret_valid), 32'd1);
        check("inst_ret_last", 32'(inst_ret_last), 32'(i == n));
        check("inst_ret_data", inst_ret_data, base + 32'(i - 1));
        check("data_ret_valid", 32'(data_ret_valid), 32'd0);
      end
      check("bus_err", 32'(bus_err), 32'((i == resp_beat) || (len_err && i == n)));
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'd0;
    #1;
    check("bus_err_idle", 32'(bus_err), 32'd0);
    check("rready_idle", 32'(rready), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inst_rd_req = 0; inst_rd_type = 3'b010; inst_rd_addr = 0;
    data_rd_req = 0; data_rd_type = 3'b010; data_rd_addr = 0;
    wr_pending = 0; wr_line_addr = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    do_reset();

    // Reset state
    #1;
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_rdy", 32'({inst_rd_rdy, data_rd_rdy}), 32'd0);
    check("rst_ret", 32'({inst_ret_valid, inst_ret_last, data_ret_valid, data_ret_last}), 32'd0);
    check("rst_ret_data", inst_ret_data | data_ret_data, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    // Single inst word read
    inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h1c00_0000;
    accept(1'b0);
    inst_rd_req = 0;
    ar_phase(4'd0, 8'd0, 3'd2, 32'h1c00_0000);
    beats(1'b0, 1, 32'h0280_0000, 0, 1'b0);

    // Data line refill
    data_rd_req = 1; data_rd_type = 3'b100; data_rd_addr = 32'h0000_1230;
    accept(1'b1);
    data_rd_req = 0;
    ar_phase(4'd1, 8'd3, 3'd2, 32'h0000_1230);
    beats(1'b1, 4, 32'h1111_0000, 0, 1'b0);

    // Round-robin with both requesting after reset: data, inst, data, inst
    do_reset();
    inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h1c00_0100;
    data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      bit d;
      d = (k % 2 == 0);
      accept(d);
      ar_phase({3'b000, d}, 8'd0, 3'd2, d ? 32'h0000_2000 : 32'h1c00_0100);
      beats(d, 1, 32'h5000_0000 + 32'(k * 16), 0, 1'b0);
    end
    inst_rd_req = 0; data_rd_req = 0;

    // Write-back hazard: data held, inst proceeds although data is favoured
    wr_pending = 1; wr_line_addr = 28'h000_0123;
    data_rd_req = 1; data_rd_addr = 32'h0000_1234;
    inst_rd_req = 1; inst_rd_addr = 32'h1c00_0200;
    accept(1'b0);
    inst_rd_req = 0;
    ar_phase(4'd0, 8'd0, 3'd2, 32'h1c00_0200);
    beats(1'b0, 1, 32'h6000_0000, 0, 1'b0);
    data_rd_addr = 32'h0000_1238;
    #1;
    check("haz_hold0", 32'(data_rd_rdy), 32'd0);
    step();
    check("haz_hold1", 32'(data_rd_rdy), 32'd0);
    wr_pending = 0;
    accept(1'b1);
    data_rd_req = 0;
    ar_phase(4'd1, 8'd0, 3'd2, 32'h0000_1238);
    beats(1'b1, 1, 32'h7000_0000, 0, 1'b0);

    // Short line (rlast on beat 2) then word read with rresp=2
    inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1c00_0300;
    accept(1'b0);
    inst_rd_req = 0;
    ar_phase(4'd0, 8'd3, 3'd2, 32'h1c00_0300);
    beats(1'b0, 2, 32'h8000_0000, 0, 1'b1);
    data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_3000;
    accept(1'b1);
    data_rd_req = 0;
    ar_phase(4'd1, 8'd0, 3'd2, 32'h0000_3000);
    beats(1'b1, 1, 32'h9000_0000, 1, 1'b0);

    // Byte read sizing
    inst_rd_req = 1; inst_rd_type = 3'b000; inst_rd_addr = 32'h1c00_0403;
    accept(1'b0);
    inst_rd_req = 0;
    ar_phase(4'd0, 8'd0, 3'd0, 32'h1c00_0403);
    beats(1'b0, 1, 32'h0000_00aa, 0, 1'b0);

    // Reset in R after one beat; stale beat must be ignored
    inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1c00_0500;
    accept(1'b0);
    inst_rd_req = 0;
    ar_phase(4'd0, 8'd3, 3'd2, 32'h1c00_0500);
    rvalid = 1; rlast = 0; rdata = 32'hdead_0001;
    #1;
    check("mid_beat1", 32'(inst_ret_valid), 32'd1);
    step();
    reset = 1;
    step();
    reset = 0;
    #1;
    check("post_rst_arvalid", 32'(arvalid), 32'd0);
    check("post_rst_rready", 32'(rready), 32'd0);
    check("post_rst_rdy", 32'({inst_rd_rdy, data_rd_rdy}), 32'd0);
    check("post_rst_stale", 32'(inst_ret_valid), 32'd0);
    rvalid = 0;
    inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h1c00_0004;
    accept(1'b0);
    inst_rd_req = 0;
    ar_phase(4'd0, 8'd0, 3'd2, 32'h1c00_0004);
    beats(1'b0, 1, 32'h0000_0bad, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
